io_port_bridge: RTL and testbench

- Host-side endpoint for the accumulator core's two parallel I/O words.
- Input direction: a host pushes 16-bit words into a holding register that continuously drives the core's IOIn.
- Output direction: watches the core's Output bus, detects each new value, and queues it in a small FIFO. A host drains that FIFO through a valid/ready handshake.
- Sits beside the accumulator top level, between the core's I/O pins and the board/testbench host.

---
 rtl/io_port_bridge.sv | 142 ++++++++++++++
 tb/tb_io_port_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// Host-side bridge for the accumulator core's I/O words: a held input word plus a change-detecting output FIFO.
// Optional build macro IO_BRIDGE_OVF_CLR_EN adds an ovf_clr input that clears the sticky overflow flag.
module io_port_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] cpu_out,
    output logic [WIDTH-1:0] cpu_in,
    input  logic [WIDTH-1:0] host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [WIDTH-1:0] host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready,
    output logic [AW:0]      fifo_count,
    output logic             overflow
`ifdef IO_BRIDGE_OVF_CLR_EN
    ,
    input  logic             ovf_clr
`endif
);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   last_out;
    logic [WIDTH-1:0]   last_d;
    logic               push_req;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;
    logic               clr;
    logic [AW:0]        count_d;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];

    assign host_in_ready = 1'b1;

`ifdef IO_BRIDGE_OVF_CLR_EN
    assign clr = ovf_clr;
`else
    assign clr = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cpu_in <= '0;
        end else if (host_in_valid) begin
            cpu_in <= host_in_data;
        end
    end

    // PRIME swallows whatever the core shows right after reset so it is never queued.
    always_comb begin
        state_d  = state_q;
        last_d   = last_out;
        push_req = 1'b0;
        case (state_q)
            PRIME: begin
                last_d  = cpu_out;
                state_d = RUN;
            end
            RUN: begin
                if (cpu_out != last_out) begin
                    push_req = 1'b1;
                    last_d   = cpu_out;
                end
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= PRIME;
            last_out <= '0;
        end else begin
            state_q  <= state_d;
            last_out <= last_d;
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign pop   = host_out_valid & host_out_ready;
    assign full  = (fifo_count == FULL);
    assign wr_en = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    always_comb begin
        count_d = fifo_count;
        case ({wr_en, pop})
            2'b10:   count_d = fifo_count + (AW+1)'(1);
            2'b01:   count_d = fifo_count - (AW+1)'(1);
            default: count_d = fifo_count;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            host_out_valid <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count     <= count_d;
            host_out_valid <= (count_d != '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= cpu_out;
        end
    end

    // Storage is not reset; an empty FIFO presents zero instead.
    assign host_out_data = host_out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_io_port_bridge.sv
// Randomized self-checking bench for io_port_bridge with a queue-based reference model.
module tb_io_port_bridge;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             CLK = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] cpu_out;
    logic [WIDTH-1:0] cpu_in;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_valid;
    logic             host_in_ready;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic [AW:0]      fifo_count;
    logic             overflow;
    logic             ovf_clr;

    io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .cpu_out        (cpu_out),
        .cpu_in         (cpu_in),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
`ifdef IO_BRIDGE_OVF_CLR_EN
        ,
        .ovf_clr        (ovf_clr)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: queue of pending words plus a few scalars.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_cpu_in;
    logic [WIDTH-1:0] m_last;
    bit               m_primed;
    bit               m_ovf;
    bit               m_pop;
    bit               m_push;
    bit               m_drop;
    bit               m_clr;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_cpu_in = '0;
            m_last   = '0;
            m_primed = 1'b0;
            m_ovf    = 1'b0;
        end else begin
`ifdef IO_BRIDGE_OVF_CLR_EN
            m_clr = ovf_clr;
`else
            m_clr = 1'b0;
`endif
            m_pop  = (m_q.size() != 0) && host_out_ready;
            m_push = m_primed && (cpu_out != m_last);
            m_drop = m_push && (m_q.size() == DEPTH) && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (m_push && !m_drop) m_q.push_back(cpu_out);
            if (m_drop) m_ovf = 1'b1;
            else if (m_clr) m_ovf = 1'b0;
            if (host_in_valid) m_cpu_in = host_in_data;
            m_last   = cpu_out;
            m_primed = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cpu_in", 32'(cpu_in), 32'(m_cpu_in));
            chk("host_in_ready", 32'(host_in_ready), 32'd1);
            chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            chk("host_out_valid", 32'(host_out_valid), 32'(m_q.size() != 0));
            chk("host_out_data", 32'(host_out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        cpu_out        = 16'h1234;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        ovf_clr        = 1'b0;
        reset          = 1'b1;
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) cyc();
        chk("rst cpu_in", 32'(cpu_in), 32'h0);
        chk("rst fifo_count", 32'(fifo_count), 32'h0);
        chk("rst host_out_valid", 32'(host_out_valid), 32'h0);
        chk("rst host_out_data", 32'(host_out_data), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);

        // Release with 0x1234 held: PRIME must absorb it.
        reset = 1'b1;
        cyc();
        cyc();
        chk("prime count", 32'(fifo_count), 32'h0);
        chk("prime valid", 32'(host_out_valid), 32'h0);

        host_in_valid = 1'b1;
        host_in_data  = 16'h00A5;
        cyc();
        host_in_valid = 1'b0;
        host_in_data  = 16'hFFFF;
        chk("cpu_in load", 32'(cpu_in), 32'h00A5);
        repeat (2) cyc();
        chk("cpu_in hold", 32'(cpu_in), 32'h00A5);

        reset = 1'b0;
        #1;
        chk("async rst cpu_in", 32'(cpu_in), 32'h0);
        cyc();
        reset = 1'b1;
        cyc();

        cpu_out = 16'h0007;
        cyc();
        chk("push valid", 32'(host_out_valid), 32'h1);
        chk("push data", 32'(host_out_data), 32'h0007);
        chk("push count", 32'(fifo_count), 32'h1);
        host_out_ready = 1'b1;
        cyc();
        host_out_ready = 1'b0;
        chk("pop count", 32'(fifo_count), 32'h0);

        for (int v = 1; v <= 5; v++) begin
            cpu_out = 16'(v);
            cyc();
        end
        chk("full count", 32'(fifo_count), 32'h4);
        chk("full overflow", 32'(overflow), 32'h1);
        host_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain data", 32'(host_out_data), 32'(i));
            cyc();
        end
        host_out_ready = 1'b0;
        chk("drained valid", 32'(host_out_valid), 32'h0);

        do_reset();
        for (int v = 16'h11; v <= 16'h14; v++) begin
            cpu_out = 16'(v);
            cyc();
        end
        cpu_out        = 16'h0009;
        host_out_ready = 1'b1;
        cyc();
        host_out_ready = 1'b0;
        chk("push+pop full count", 32'(fifo_count), 32'h4);
        chk("push+pop full ovf", 32'(overflow), 32'h0);
        chk("push+pop full head", 32'(host_out_data), 32'h0012);

        do_reset();
        cpu_out = 16'h0042;
        repeat (10) cyc();
        chk("hold single entry", 32'(fifo_count), 32'h1);
        chk("hold single data", 32'(host_out_data), 32'h0042);

`ifdef IO_BRIDGE_OVF_CLR_EN
        do_reset();
        for (int v = 16'h21; v <= 16'h25; v++) begin
            cpu_out = 16'(v);
            cyc();
        end
        chk("clr pre ovf", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("clr ovf", 32'(overflow), 32'h0);
        cpu_out = 16'h0026;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("clr vs drop", 32'(overflow), 32'h1);
`endif

        for (int n = 0; n < 600; n++) begin
            cpu_out        = 16'($urandom_range(0, 3));
            host_out_ready = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            host_in_valid  = $urandom_range(0, 1);
            host_in_data   = 16'($urandom);
`ifdef IO_BRIDGE_OVF_CLR_EN
            ovf_clr        = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 99) == 0) reset = 1'b0;
            else reset = 1'b1;
            cyc();
        end
        reset = 1'b1;
        cyc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
